pwm_duty_controller: RTL and testbench

//  Sequences the PWM datapath: accepts duty-cycle requests (0..STEPS, as produced by the one-hot

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_prescaler.sv | 31 +++
 rtl/pwm_duty_controller.sv | 137 +++++++++++++
 tb/tb_pwm_duty_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty controller slice.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned STEPS_DEF   = 8;
  localparam int unsigned DUTY_CALC_W = 16;

  // Limit a requested duty to the legal range 0..steps.
  function automatic logic [DUTY_CALC_W-1:0] clamp_duty(
    input logic [DUTY_CALC_W-1:0] duty,
    input logic [DUTY_CALC_W-1:0] steps
  );
    return (duty > steps) ? steps : duty;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: divides clk into one-cycle ticks every PRESC cycles while enabled.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC   = 1000,
  parameter int unsigned PRESC_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned   CW   = (PRESC_W < 1) ? 1 : PRESC_W;
  localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

  logic [CW-1:0] cnt;

  // Count 0..PRESC-1 while enabled; held at zero when cleared.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/pwm_duty_controller.sv
// PWM duty controller: handshakes duty requests, applies them at period
// boundaries, runs the step counter and drives the registered PWM output.
// Optional build macro PWM_SOFTSTART_EN: duty_active ramps one step per
// update toward the requested value instead of jumping.
module pwm_duty_controller
  import pwm_pkg::*;
#(
  parameter int unsigned STEPS   = STEPS_DEF,
  parameter int unsigned DUTY_W  = 4,
  parameter int unsigned PRESC   = 1000,
  parameter int unsigned PRESC_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic [DUTY_W-1:0] duty_active,
  output logic              period_start,
  output logic              busy,
  output logic              pwm_out
);

  localparam int unsigned       STEP_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] step;
  logic [DUTY_W-1:0] pend_duty;
  logic [DUTY_W-1:0] duty_req_c;
  logic [DUTY_W-1:0] duty_nxt_c;
  logic              tick_c;
  logic              run_c;
  logic              boundary_c;
  logic              accept_c;
  logic              apply_c;
  logic              apply_done_c;

  assign run_c      = (state != IDLE);
  assign boundary_c = tick_c && (step == STEP_LAST);
  assign accept_c   = duty_valid && duty_ready;
  assign duty_req_c = DUTY_W'(clamp_duty(DUTY_CALC_W'(duty_in), DUTY_CALC_W'(STEPS)));

  pwm_prescaler #(
    .PRESC   (PRESC),
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (run_c),
    .clr    (!run_c),
    .tick_c (tick_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: STOP only retires to IDLE at a period boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = STOP;
      STOP: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (boundary_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending-duty update: immediately while idle, otherwise only at a boundary.
  always_comb begin
    duty_nxt_c   = duty_active;
    apply_done_c = 1'b0;
    apply_c      = !duty_ready && ((state == IDLE) || boundary_c);
`ifdef PWM_SOFTSTART_EN
    if (duty_active < pend_duty) begin
      duty_nxt_c = duty_active + DUTY_W'(1);
    end else if (duty_active > pend_duty) begin
      duty_nxt_c = duty_active - DUTY_W'(1);
    end
    apply_done_c = apply_c && (duty_nxt_c == pend_duty);
`else
    duty_nxt_c   = pend_duty;
    apply_done_c = apply_c;
`endif
  end

  // Step counter, handshake/pending registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      step         <= '0;
      duty_active  <= '0;
      pend_duty    <= '0;
      duty_ready   <= 1'b1;
      period_start <= 1'b0;
      busy         <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      busy         <= (state_nxt != IDLE);
      period_start <= ((state == IDLE) && (state_nxt == RUN)) ||
                      (boundary_c && (state_nxt != IDLE));
      pwm_out      <= run_c && (DUTY_W'(step) < duty_active);

      if (!run_c) begin
        step <= '0;
      end else if (tick_c) begin
        step <= (step == STEP_LAST) ? '0 : step + STEP_W'(1);
      end

      if (apply_c) begin
        duty_active <= duty_nxt_c;
      end

      // Accept and apply are exclusive: accept needs ready, apply needs a pending value.
      if (accept_c) begin
        pend_duty  <= duty_req_c;
        duty_ready <= 1'b0;
      end else if (apply_done_c) begin
        duty_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Bench for pwm_duty_controller (STEPS=8, PRESC=2: 16-clk periods).
module tb_pwm_duty_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       duty_valid = 1'b0;
  logic [3:0] duty_in = 4'd0;
  logic       duty_ready;
  logic [3:0] duty_active;
  logic       period_start;
  logic       busy;
  logic       pwm_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] da;
    int         hi;
  } win_t;

  win_t       exp_win[$];
  logic [3:0] exp_apply[$];

  always #5 clk = ~clk;

  pwm_duty_controller #(
    .STEPS   (8),
    .DUTY_W  (4),
    .PRESC   (2),
    .PRESC_W (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .duty_active  (duty_active),
    .period_start (period_start),
    .busy         (busy),
    .pwm_out      (pwm_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no matching event expected one", name);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_win(input logic [3:0] da, input int hi, input int n);
    win_t w;
    w.da = da;
    w.hi = hi;
    repeat (n) exp_win.push_back(w);
  endtask

  // Returns at the negedge of the n-th period_start pulse seen.
  task automatic wait_ps(input int n);
    int seen = 0;
    for (int i = 0; i < 40 * n + 40 && seen < n; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) seen++;
    end
    if (seen < n) fail_event("wait_period_start_timeout");
  endtask

  // Hold valid until ready is seen, accept on the following posedge.
  task automatic send_duty(input logic [3:0] d, input logic [3:0] e);
    bit ok = 1'b0;
    exp_apply.push_back(e);
    duty_in    = d;
    duty_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (duty_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) fail_event("send_duty_timeout");
    @(posedge clk);
    #1;
    duty_valid = 1'b0;
  endtask

  // Monitor: one window per period (pwm lags step by one clk), plus ready-rise events.
  task automatic run_monitor();
    logic       prev_ready = 1'b1;
    bit         in_win = 1'b0;
    int         wcnt = 0;
    int         hcnt = 0;
    logic [3:0] wda = 4'd0;
    win_t       w;
    logic [3:0] ea;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        in_win     = 1'b0;
        prev_ready = 1'b1;
      end else begin
        if (in_win) begin
          if (pwm_out === 1'b1) hcnt++;
          wcnt++;
          if (wcnt == 16) begin
            in_win = 1'b0;
            if (exp_win.size() == 0) begin
              fail_event("period_unexpected");
            end else begin
              w = exp_win.pop_front();
              chk("period_duty", 32'(wda), 32'(w.da));
              chk("period_high_clks", 32'(hcnt), 32'(w.hi));
            end
          end
        end
        if (period_start === 1'b1) begin
          in_win = 1'b1;
          wcnt   = 0;
          hcnt   = 0;
          wda    = duty_active;
        end
        if (duty_ready === 1'b1 && prev_ready === 1'b0) begin
          if (exp_apply.size() == 0) begin
            fail_event("apply_unexpected");
          end else begin
            ea = exp_apply.pop_front();
            chk("applied_duty", 32'(duty_active), 32'(ea));
          end
        end
        prev_ready = duty_ready;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_monitor();
    join_none

    // Reset values
    nclk(2);
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_duty_active", 32'(duty_active), 32'd0);
    chk("rst_duty_ready", 32'(duty_ready), 32'd1);
    chk("rst_period_start", 32'(period_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef PWM_SOFTSTART_EN
    // Ramp 0 -> 4, one step per boundary
    enable = 1'b1;
    wait_ps(1);
    push_win(4'd0, 0, 1);
    nclk(3);
    send_duty(4'd4, 4'd4);
    push_win(4'd1, 2, 1);
    push_win(4'd2, 4, 1);
    push_win(4'd3, 6, 1);
    push_win(4'd4, 8, 1);
    wait_ps(3);
    chk("ss_ready_after_3", 32'(duty_ready), 32'd0);
    chk("ss_duty_after_3", 32'(duty_active), 32'd3);
    wait_ps(1);
    chk("ss_ready_after_4", 32'(duty_ready), 32'd1);
    chk("ss_duty_after_4", 32'(duty_active), 32'd4);
    wait_ps(1);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    nclk(2);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nclk(2);
`else
    // Duty 3 accepted in IDLE, then run three periods
    send_duty(4'd3, 4'd3);
    nclk(2);
    chk("idle_duty_active", 32'(duty_active), 32'd3);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pwm_out", 32'(pwm_out), 32'd0);
    push_win(4'd3, 6, 3);
    enable = 1'b1;
    wait_ps(1);
    chk("run_busy", 32'(busy), 32'd1);
    wait_ps(3);

    // Duty 0 then duty 8 over three periods each
    push_win(4'd3, 6, 1);
    send_duty(4'd0, 4'd0);
    push_win(4'd0, 0, 3);
    wait_ps(4);
    push_win(4'd0, 0, 1);
    send_duty(4'd8, 4'd8);
    push_win(4'd8, 16, 3);
    wait_ps(4);

    // Duty 5 mid-period: held pending until the boundary
    push_win(4'd8, 16, 1);
    nclk(5);
    send_duty(4'd5, 4'd5);
    nclk(1);
    chk("mid_ready_low", 32'(duty_ready), 32'd0);
    nclk(8);
    chk("mid_ready_low_late", 32'(duty_ready), 32'd0);
    chk("mid_duty_old", 32'(duty_active), 32'd8);
    push_win(4'd5, 10, 1);
    wait_ps(1);
    chk("next_period_duty", 32'(duty_active), 32'd5);
    chk("next_period_ready", 32'(duty_ready), 32'd1);

    // Duty 12 accepted on the boundary cycle: clamps to 8, applies one period later
    nclk(15);
    send_duty(4'd12, 4'd8);
    push_win(4'd5, 10, 1);
    push_win(4'd8, 16, 1);
    nclk(1);
    chk("boundary_accept_not_applied", 32'(duty_active), 32'd5);
    chk("boundary_accept_ready", 32'(duty_ready), 32'd0);
    duty_in    = 4'd1;
    duty_valid = 1'b1;
    nclk(6);
    chk("ignored_valid_ready", 32'(duty_ready), 32'd0);
    duty_valid = 1'b0;
    wait_ps(1);
    chk("clamped_duty", 32'(duty_active), 32'd8);

    // Enable dropped at step 2: period completes, then IDLE
    nclk(4);
    enable = 1'b0;
    nclk(11);
    chk("stop_busy_before_boundary", 32'(busy), 32'd1);
    nclk(1);
    chk("stop_busy_after_boundary", 32'(busy), 32'd0);
    chk("stop_no_period_start", 32'(period_start), 32'd0);
    nclk(1);
    chk("stop_pwm_low", 32'(pwm_out), 32'd0);

    // Restart, then reset at step 4
    enable = 1'b1;
    wait_ps(1);
    nclk(8);
    @(posedge clk);
    #1;
    reset = 1'b1;
    nclk(2);
    chk("midrst_pwm_out", 32'(pwm_out), 32'd0);
    chk("midrst_duty_active", 32'(duty_active), 32'd0);
    chk("midrst_duty_ready", 32'(duty_ready), 32'd1);
    chk("midrst_period_start", 32'(period_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    nclk(1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    nclk(2);
`endif

    chk("period_queue_drained", 32'(exp_win.size()), 32'd0);
    chk("apply_queue_drained", 32'(exp_apply.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
